tt_um_bitcoin_core: RTL and testbench

TT_UM_BITCOIN_CORE -- requirements
Module: tt_um_bitcoin

---
 rtl/tt_um_bitcoin_core.sv | 239 +++++++++++++++++++++++
 tb/tb_tt_um_bitcoin_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_bitcoin_core.sv
// Double SHA-256 of an 80-byte block header fetched byte-by-byte over a rq/rdy handshake.
// One shared iterative compression core runs the three blocks; the digest is streamed out the same way.
module tt_um_bitcoin_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HASH, S_OUT} state_t;
    typedef enum logic [1:0] {BLK_A, BLK_B, BLK_C} blk_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t      state_q, state_d;
    blk_t        blk_q, blk_d;
    logic [6:0]  addr_q, addr_d;
    logic [6:0]  rnd_q, rnd_d;
    logic        rq_q, rq_d;
    logic        done_q, done_d;
    logic [7:0]  uo_q, uo_d;

    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] wk_q [8];
    logic [31:0] wk_d [8];
    logic [31:0] hv_q [8];
    logic [31:0] hv_d [8];

    logic        start, rdy;
    logic [31:0] t1, t2, w_new;
    logic [31:0] sum [8];
    logic [4:0]  out_nxt;
    logic [7:0]  out_byte;
    logic        unused_ok;

    assign start     = uio_in[0];
    assign rdy       = uio_in[1];
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

    assign uo_out  = uo_q;
    assign uio_out = {4'b0000, done_q, rq_q, 2'b00};
    assign uio_oe  = 8'b0000_1100;

    assign t1 = wk_q[7] + big_s1(wk_q[4]) + ch(wk_q[4], wk_q[5], wk_q[6]) + K[rnd_q[5:0]] + w_q[0];
    assign t2 = big_s0(wk_q[0]) + maj(wk_q[0], wk_q[1], wk_q[2]);
    // w_q[0..15] always holds W[t..t+15]; this is W[t+16]
    assign w_new = sml_s1(w_q[14]) + w_q[9] + sml_s0(w_q[1]) + w_q[0];

    assign out_nxt  = addr_q[4:0] + 5'd1;
    assign out_byte = hv_q[out_nxt[4:2]][{~out_nxt[1:0], 3'b000} +: 8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum[i] = hv_q[i] + wk_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        addr_d  = addr_q;
        rnd_d   = rnd_q;
        rq_d    = rq_q;
        done_d  = done_q;
        uo_d    = uo_q;
        w_d     = w_q;
        wk_d    = wk_q;
        hv_d    = hv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    blk_d   = BLK_A;
                    addr_d  = 7'd0;
                    uo_d    = 8'd0;
                    rq_d    = 1'b0;
                    hv_d    = IV;
                end
            end

            S_FETCH: begin
                if (!rq_q) begin
                    rq_d = 1'b1;
                end else if (rdy) begin
                    rq_d = 1'b0;
                    w_d[addr_q[5:2]][{~addr_q[1:0], 3'b000} +: 8] = ui_in;
                    addr_d = addr_q + 7'd1;
                    if (addr_q == 7'd63 || addr_q == 7'd79) begin
                        state_d = S_HASH;
                        rnd_d   = 7'd0;
                        wk_d    = hv_q;
                    end else begin
                        uo_d = {1'b0, addr_q + 7'd1};
                    end
                end
            end

            S_HASH: begin
                if (!rnd_q[6]) begin
                    wk_d = '{t1 + t2, wk_q[0], wk_q[1], wk_q[2], wk_q[3] + t1, wk_q[4], wk_q[5], wk_q[6]};
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i + 1];
                    end
                    w_d[15] = w_new;
                    rnd_d   = rnd_q + 7'd1;
                end else begin
                    hv_d  = sum;
                    rnd_d = 7'd0;
                    case (blk_q)
                        BLK_A: begin
                            // Pre-pad the second block; only words 0..3 come from the host
                            state_d = S_FETCH;
                            blk_d   = BLK_B;
                            rq_d    = 1'b0;
                            uo_d    = {1'b0, addr_q};
                            w_d[4]  = 32'h8000_0000;
                            for (int i = 5; i < 15; i++) begin
                                w_d[i] = 32'd0;
                            end
                            w_d[15] = 32'd640;
                        end
                        BLK_B: begin
                            // Second pass hashes the 32-byte first digest from a fresh IV
                            blk_d = BLK_C;
                            for (int i = 0; i < 8; i++) begin
                                w_d[i] = sum[i];
                            end
                            w_d[8] = 32'h8000_0000;
                            for (int i = 9; i < 15; i++) begin
                                w_d[i] = 32'd0;
                            end
                            w_d[15] = 32'd256;
                            hv_d    = IV;
                            wk_d    = IV;
                        end
                        default: begin
                            state_d = S_OUT;
                            addr_d  = 7'd0;
                            done_d  = 1'b1;
                            rq_d    = 1'b0;
                            uo_d    = sum[0][31:24];
                        end
                    endcase
                end
            end

            S_OUT: begin
                if (!rq_q) begin
                    rq_d = 1'b1;
                end else if (rdy) begin
                    rq_d = 1'b0;
                    if (addr_q == 7'd31) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                        addr_d  = 7'd0;
                        uo_d    = 8'd0;
                    end else begin
                        addr_d = addr_q + 7'd1;
                        uo_d   = out_byte;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            blk_q   <= BLK_A;
            addr_q  <= 7'd0;
            rnd_q   <= 7'd0;
            rq_q    <= 1'b0;
            done_q  <= 1'b0;
            uo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            addr_q  <= addr_d;
            rnd_q   <= rnd_d;
            rq_q    <= rq_d;
            done_q  <= done_d;
            uo_q    <= uo_d;
        end
    end

    // Datapath storage carries no reset; control decides when it is meaningful
    always_ff @(posedge clk) begin
        w_q  <= w_d;
        wk_q <= wk_d;
        hv_q <= hv_d;
    end

endmodule

// File: tb/tb_tt_um_bitcoin_core.sv
// Directed bench for tt_um_bitcoin_core: genesis-header double hash, handshake timing,
// mid-run resets, back-to-back runs and cycle budget.
module tb_tt_um_bitcoin_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int oe_bad = 0;

    localparam logic [639:0] GENESIS = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
    localparam logic [255:0] GENESIS_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    tt_um_bitcoin_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uio_oe !== 8'h0C) oe_bad <= oe_bad + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Software reference: straightforward full-schedule SHA-256
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] mdl_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
        return res;
    endfunction

    function automatic logic [255:0] mdl_sha256d(input logic [639:0] hdr);
        logic [255:0] h;
        h = mdl_compress(IV256, hdr[639:128]);
        h = mdl_compress(h, {hdr[127:0], 8'h80, 312'd0, 64'd640});
        return mdl_compress(IV256, {h, 8'h80, 184'd0, 64'd256});
    endfunction

    task automatic wait_rq(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (uio_out[2] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("rq_timeout", 0, 1);
    endtask

    // Called on the negedge where rq is seen high; holds off dly cycles then pulses rdy.
    task automatic ack(input int dly, input logic [7:0] data, input logic exp_done);
        logic [7:0] held;
        held = uo_out;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            check_eq("rq_hold", uio_out[2], 1'b1);
            check_eq("uo_hold", uo_out, held);
            check_eq("done_hold", uio_out[3], exp_done);
        end
        ui_in = data;
        uio_in[1] = 1'b1;
        @(negedge clk);
        uio_in[1] = 1'b0;
        check_eq("rq_drop", uio_out[2], 1'b0);
    endtask

    function automatic int pick_delay(input int maxd);
        if (maxd == 0) return 0;
        return int'($urandom_range(maxd, 0));
    endfunction

    // abort_at: -1 full run, 0..79 stop when that address is requested, 80 stop inside HASH(B)
    task automatic run_hash(input logic [639:0] hdr, input int maxd, input int abort_at, input bit hold_start,
                            output logic [255:0] dig, output int ncyc);
        bit ok;
        int t0;
        dig = '0;
        ncyc = 0;
        uio_in[0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        if (!hold_start) uio_in[0] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            wait_rq(300, ok);
            if (!ok) return;
            if (i == abort_at) return;
            check_eq("fetch_addr", uo_out, i);
            check_eq("done_in_fetch", uio_out[3], 1'b0);
            ack(pick_delay(maxd), hdr[639 - 8*i -: 8], 1'b0);
        end
        if (abort_at == 80) begin
            repeat (20) @(negedge clk);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            wait_rq(300, ok);
            if (!ok) return;
            check_eq("done_at_rq", uio_out[3], 1'b1);
            dig[255 - 8*i -: 8] = uo_out;
            ack(pick_delay(maxd), 8'h00, 1'b1);
            check_eq("done_after_ack", uio_out[3], (i < 31) ? 1'b1 : 1'b0);
        end
        ncyc = cyc - t0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_uo_out", uo_out, 8'h00);
        check_eq("rst_uio_out", uio_out, 8'h00);
        repeat (2) @(negedge clk);
        check_eq("rst_hold_uio_out", uio_out, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_no_rq", uio_out[2], 1'b0);
    endtask

    initial begin
        logic [255:0] dig;
        int ncyc;
        bit ok;

        #2;
        check_eq("reset_uo_out", uo_out, 8'h00);
        check_eq("reset_uio_out", uio_out, 8'h00);
        check_eq("reset_uio_oe", uio_oe, 8'h0C);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_waits_start", uio_out[2], 1'b0);

        run_hash(GENESIS, 0, -1, 1'b0, dig, ncyc);
        check_eq("genesis_fast", dig, GENESIS_HASH);
        check_eq("cycle_budget", (ncyc > 0 && ncyc <= 80*3 + 32*3 + 3*68 + 10), 1);

        run_hash(GENESIS, 20, -1, 1'b0, dig, ncyc);
        check_eq("genesis_slow_host", dig, GENESIS_HASH);

        run_hash(GENESIS, 0, 40, 1'b0, dig, ncyc);
        do_reset();
        run_hash(GENESIS, 0, 80, 1'b0, dig, ncyc);
        do_reset();
        run_hash(GENESIS, 3, -1, 1'b0, dig, ncyc);
        check_eq("genesis_after_resets", dig, GENESIS_HASH);

        run_hash(640'd0, 2, -1, 1'b1, dig, ncyc);
        check_eq("zero_header", dig, mdl_sha256d(640'd0));

        wait_rq(10, ok);
        check_eq("restart_on_held_start", uio_out[2], 1'b1);
        check_eq("restart_addr0", uo_out, 8'h00);
        uio_in[0] = 1'b0;
        do_reset();

        check_eq("uio_oe_constant", oe_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
